// File: rtl/pe_stripes_seq_ctrl_pkg.sv
// Shared types and width helpers for the PE_stripes sequencer
// and the PE_stripes datapath wrappers.
package pe_stripes_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int calc_out_width(input int w, input int n, input int mp);
      return w + $clog2(n) + mp;
   endfunction

   function automatic int calc_pw(input int mp);
      return $clog2(mp + 1);
   endfunction

endpackage

// File: rtl/pe_stripes_seq_ctrl_slicer.sv
// N-lane bit picker: bit idx_i of every MP-bit lane.
module pe_stripes_seq_ctrl_slicer #(
   parameter int N  = 4,
   parameter int MP = 16,
   parameter int PW = 5
) (
   input  logic [N*MP-1:0] vec_i,
   input  logic [PW-1:0]   idx_i,
   output logic [N-1:0]    bits_o
);

   always_comb begin
      bits_o = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < MP; j++) begin
            if (idx_i == PW'(j)) bits_o[i] = vec_i[i*MP+j];
         end
      end
   end

endmodule

// File: rtl/pe_stripes_seq_ctrl.sv
// Job sequencer for one bit-serial PE_stripes instance:
// serialises A MSB-first and returns the PE result.
module pe_stripes_seq_ctrl
   import pe_stripes_seq_ctrl_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int W         = 16,
   parameter  int MP        = 16,
   localparam int OUT_WIDTH = calc_out_width(W, N, MP),
   localparam int PW        = calc_pw(MP)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [N*MP-1:0]      s_vec_a,
   input  logic [N*W-1:0]       s_vec_b,
   input  logic [OUT_WIDTH-1:0] s_init_sum,
   input  logic [PW-1:0]        s_prec,
   output logic                 o_pe_valid,
   output logic                 o_pe_is_msb,
   output logic                 o_pe_is_lsb,
   output logic [N-1:0]         o_pe_a_bits,
   output logic [N*W-1:0]       o_pe_vec_b,
   output logic [OUT_WIDTH-1:0] o_pe_init_sum,
   input  logic [OUT_WIDTH-1:0] i_pe_dot_product,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [OUT_WIDTH-1:0] m_result,
   output logic                 o_busy
);

   localparam logic [PW-1:0] MP_P = PW'(MP);
   localparam logic [PW-1:0] ONE  = PW'(1);

   state_e                 state_q;
   logic [N*MP-1:0]        a_q;
   logic [N*W-1:0]         b_q;
   logic [OUT_WIDTH-1:0]   init_q;
   logic [OUT_WIDTH-1:0]   result_q;
   logic [PW-1:0]          k_q;
   logic                   pe_valid_q;
   logic                   msb_q;
   logic                   lsb_q;
   logic [N-1:0]           a_bits_q;

   logic [PW-1:0]          p_eff_d;
   logic [N*MP-1:0]        slice_vec_d;
   logic [PW-1:0]          slice_idx_d;
   logic [N-1:0]           slice_bits_d;

   // Precision 0 or beyond MP means full width.
   always_comb begin
      p_eff_d = s_prec;
      if (s_prec == '0 || s_prec > MP_P) p_eff_d = MP_P;
   end

   // Slice ahead of time so the PE bits come straight from a register.
   always_comb begin
      slice_vec_d = a_q;
      slice_idx_d = k_q - ONE;
      if (state_q == ST_IDLE) begin
         slice_vec_d = s_vec_a;
         slice_idx_d = p_eff_d - ONE;
      end
   end

   pe_stripes_seq_ctrl_slicer #(
      .N  (N),
      .MP (MP),
      .PW (PW)
   ) u_slicer (
      .vec_i  (slice_vec_d),
      .idx_i  (slice_idx_d),
      .bits_o (slice_bits_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         init_q     <= '0;
         result_q   <= '0;
         k_q        <= '0;
         pe_valid_q <= 1'b0;
         msb_q      <= 1'b0;
         lsb_q      <= 1'b0;
         a_bits_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (s_valid) begin
                  a_q        <= s_vec_a;
                  b_q        <= s_vec_b;
                  init_q     <= s_init_sum;
                  k_q        <= p_eff_d - ONE;
                  pe_valid_q <= 1'b1;
                  msb_q      <= 1'b1;
                  lsb_q      <= (p_eff_d == ONE);
                  a_bits_q   <= slice_bits_d;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (lsb_q) begin
                  result_q   <= i_pe_dot_product;
                  pe_valid_q <= 1'b0;
                  msb_q      <= 1'b0;
                  lsb_q      <= 1'b0;
                  a_bits_q   <= '0;
                  state_q    <= ST_DONE;
               end else begin
                  k_q      <= k_q - ONE;
                  a_bits_q <= slice_bits_d;
                  msb_q    <= 1'b0;
                  lsb_q    <= (k_q == ONE);
               end
            end
            ST_DONE: begin
               if (m_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_ready       = (state_q == ST_IDLE);
   assign m_valid       = (state_q == ST_DONE);
   assign o_busy        = (state_q != ST_IDLE);
   assign m_result      = result_q;
   assign o_pe_valid    = pe_valid_q;
   assign o_pe_is_msb   = msb_q;
   assign o_pe_is_lsb   = lsb_q;
   assign o_pe_a_bits   = a_bits_q;
   assign o_pe_vec_b    = b_q;
   assign o_pe_init_sum = init_q;

endmodule

// File: tb/tb_pe_stripes_seq_ctrl.sv
// Directed bench for pe_stripes_seq_ctrl with a behavioural
// bit-serial PE closing the loop.
module tb_pe_stripes_seq_ctrl;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int MP = 16;
   localparam int OW = 34;
   localparam int PW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [N*MP-1:0] s_vec_a;
   logic [N*W-1:0]  s_vec_b;
   logic [OW-1:0]   s_init_sum;
   logic [PW-1:0]   s_prec;
   logic          o_pe_valid;
   logic          o_pe_is_msb;
   logic          o_pe_is_lsb;
   logic [N-1:0]  o_pe_a_bits;
   logic [N*W-1:0]  o_pe_vec_b;
   logic [OW-1:0]   o_pe_init_sum;
   logic [OW-1:0]   i_pe_dot_product;
   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0]   m_result;
   logic          o_busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pe_stripes_seq_ctrl #(.N(N), .W(W), .MP(MP)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_vec_a          (s_vec_a),
      .s_vec_b          (s_vec_b),
      .s_init_sum       (s_init_sum),
      .s_prec           (s_prec),
      .o_pe_valid       (o_pe_valid),
      .o_pe_is_msb      (o_pe_is_msb),
      .o_pe_is_lsb      (o_pe_is_lsb),
      .o_pe_a_bits      (o_pe_a_bits),
      .o_pe_vec_b       (o_pe_vec_b),
      .o_pe_init_sum    (o_pe_init_sum),
      .i_pe_dot_product (i_pe_dot_product),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_result         (m_result),
      .o_busy           (o_busy)
   );

   // Behavioural PE: MSB carries negative weight, result ready in LSB cycle.
   logic signed [OW-1:0] pe_acc_q;
   logic signed [OW-1:0] pe_sum;
   logic signed [OW-1:0] pe_cur;

   always_comb begin
      pe_sum = '0;
      for (int i = 0; i < N; i++) begin
         if (o_pe_a_bits[i]) pe_sum = pe_sum + OW'($signed(o_pe_vec_b[i*W+:W]));
      end
      pe_cur = o_pe_is_msb ? -pe_sum : (pe_acc_q <<< 1) + pe_sum;
      i_pe_dot_product = pe_cur + o_pe_init_sum;
   end

   always_ff @(posedge clk) begin
      if (o_pe_valid) pe_acc_q <= pe_cur;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_job(input string tag, input int a[4], input int b[4],
                          input longint init, input int prec, input int p,
                          input longint exp_res, input bit hold);
      int guard, lat, cyc, msb_n, lsb_n, msb_at, lsb_at, bit_err, hold_err;
      logic [MP-1:0] av;
      logic [N*W-1:0] bv;
      logic [OW-1:0] held;
      bit done;
      guard = 0;
      while (!s_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < N; i++) begin
         s_vec_a[i*MP+:MP] = MP'(a[i]);
         s_vec_b[i*W+:W]   = W'(b[i]);
      end
      bv = s_vec_b;
      s_init_sum = OW'(init);
      s_prec     = PW'(prec);
      m_ready    = !hold;
      s_valid    = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      lat = 0; cyc = 0; msb_n = 0; lsb_n = 0;
      msb_at = 0; lsb_at = 0; bit_err = 0; done = 0;
      while (!done && lat < 40) begin
         lat++;
         if (o_pe_valid) begin
            cyc++;
            if (o_pe_is_msb) begin msb_n++; msb_at = cyc; end
            if (o_pe_is_lsb) begin lsb_n++; lsb_at = cyc; end
            if (o_pe_vec_b !== bv || o_pe_init_sum !== OW'(init)) bit_err++;
            for (int i = 0; i < N; i++) begin
               av = MP'(a[i]);
               if (cyc <= p && o_pe_a_bits[i] !== av[p-cyc]) bit_err++;
            end
         end
         if (m_valid) done = 1;
         else @(negedge clk);
      end
      chk({tag, "_timeout"}, longint'(done), 1);
      chk({tag, "_pe_cycles"}, cyc, p);
      chk({tag, "_msb_count"}, msb_n, 1);
      chk({tag, "_msb_first"}, msb_at, 1);
      chk({tag, "_lsb_count"}, lsb_n, 1);
      chk({tag, "_lsb_last"}, lsb_at, p);
      chk({tag, "_lane_bits"}, bit_err, 0);
      chk({tag, "_latency"}, lat, p + 1);
      chk({tag, "_result"}, longint'($signed(m_result)), exp_res);
      if (hold) begin
         held = m_result;
         hold_err = 0;
         for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
               s_vec_a = '1;
               s_prec  = PW'(1);
               s_valid = 1'b1;
            end
            @(negedge clk);
            if (m_result !== held || m_valid !== 1'b1 || s_ready !== 1'b0) hold_err++;
         end
         s_valid = 1'b0;
         chk({tag, "_hold_stable"}, hold_err, 0);
         chk({tag, "_hold_result"}, longint'($signed(m_result)), exp_res);
         m_ready = 1'b1;
         @(negedge clk);
         chk({tag, "_release_mvalid"}, longint'(m_valid), 0);
         chk({tag, "_release_sready"}, longint'(s_ready), 1);
         chk({tag, "_release_busy"}, longint'(o_busy), 0);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sready"}, longint'(s_ready), 1);
      chk({tag, "_pe_valid"}, longint'(o_pe_valid), 0);
      chk({tag, "_msb_lsb"}, longint'({o_pe_is_msb, o_pe_is_lsb}), 0);
      chk({tag, "_a_bits"}, longint'(o_pe_a_bits), 0);
      chk({tag, "_mvalid"}, longint'(m_valid), 0);
      chk({tag, "_busy"}, longint'(o_busy), 0);
      chk({tag, "_result"}, longint'(m_result), 0);
   endtask

   initial begin
      int mv;
      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_vec_a    = '0;
      s_vec_b    = '0;
      s_init_sum = '0;
      s_prec     = '0;
      m_ready    = 1'b1;
      #1;
      chk_reset_outputs("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_job("t1_p16", '{1, -4, 6, 3}, '{2, 6, -1, 7}, 0, 16, 16, -7, 0);
      run_job("t2_p4", '{1, -4, 6, 3}, '{2, 6, -1, 7}, 0, 4, 4, -7, 0);
      run_job("t2_p0", '{1, -4, 6, 3}, '{2, 6, -1, 7}, 0, 0, 16, -7, 0);
      run_job("t3_init", '{1, -4, 6, 3}, '{2, 6, -1, 7}, 100, 16, 16, 93, 0);
      run_job("t3_b2b", '{2, 2, 2, 2}, '{1, 1, 1, 1}, 0, 16, 16, 8, 0);
      run_job("t4_p1", '{1, 0, 1, 0}, '{2, 6, -1, 7}, 0, 1, 1, -1, 0);
      run_job("t5_hold", '{1, -4, 6, 3}, '{2, 6, -1, 7}, 0, 4, 4, -7, 1);

      // Reset in the middle of a 16-bit job, at bit index 8.
      for (int i = 0; i < N; i++) s_vec_a[i*MP+:MP] = '1;
      s_prec  = PW'(16);
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("t6_pre_busy", longint'(o_busy), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_midrun");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mv = 0;
      repeat (25) begin
         @(negedge clk);
         if (m_valid) mv++;
      end
      chk("t6_no_result", mv, 0);
      run_job("t6_fresh", '{1, -4, 6, 3}, '{2, 6, -1, 7}, 0, 16, 16, -7, 0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
